// File: rtl/vcve2_dmem_responder.sv
// Data-memory responder for a req/gnt/rvalid initiator: word storage with byte
// enables, fixed-latency in-order responses and an outstanding-transaction limit.
module vcve2_dmem_responder #(
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned DepthWords     = 1024,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned IdxW      = (DepthWords > 1) ? $clog2(DepthWords) : 1;
  localparam logic [32:0] SpanBytes = 33'(DepthWords) * 33'd4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic [31:0]     mem_q [DepthWords];
  rsp_t            pipe_q [Latency];
  rsp_t            pipe_d [Latency];
  rsp_t            rsp_new;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept, launch, in_range;
  logic [32:0]     offset;
  logic [IdxW-1:0] word_idx;

  // A transaction stops counting on the edge that loads its response into the
  // output stage, so with MaxOutstanding >= Latency a streaming initiator is never stalled.
  assign data_gnt_o = rst_ni && data_req_i && (cnt_q < 4'(MaxOutstanding));
  assign accept     = data_gnt_o;

  // 33-bit difference: addresses below BaseAddr wrap to huge offsets and fail the range test.
  assign offset   = {1'b0, data_addr_i} - {1'b0, BaseAddr};
  assign in_range = offset < SpanBytes;
  assign word_idx = offset[IdxW+1:2];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rsp_new = '0;
    if (accept) begin
      rsp_new.valid = 1'b1;
      rsp_new.err   = !in_range;
      rsp_new.rdata = (!data_we_i && in_range) ? mem_q[word_idx] : 32'h0;
    end
  end

  always_comb begin
    pipe_d[0] = rsp_new;
    for (int i = 1; i < int'(Latency); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign launch = pipe_d[Latency-1].valid;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, launch})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(Latency); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < int'(Latency); i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive rst_ni and map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  assign data_rvalid_o = pipe_q[Latency-1].valid;
  assign data_err_o    = pipe_q[Latency-1].err;
  assign data_rdata_o  = pipe_q[Latency-1].rdata;

endmodule
